// File: rtl/fir_pkg.sv
// Shared definitions for the shaping filter pair (forward filter and its inverse):
// default sample width, priming length, settle-state encoding and a sign-extension helper.
package fir_pkg;

  // Default sample width used when a filter instance does not override it.
  localparam int NB_DATA_DEF = 8;

  // Extra headroom bits needed so the six-term sums cannot overflow.
  localparam int NB_GUARD = 3;

  // Extended width that holds full-precision filter sums.
  localparam int NB_EXT_DEF = NB_DATA_DEF + NB_GUARD;

  // Number of accepted samples needed before every history tap holds real data.
  localparam int FILL_LEN = 3;

  // Settle state: FILL while history is being primed, RUN once fully primed.
  typedef enum logic {
    FILL = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Sign-extends a default-width sample to the extended arithmetic width.
  function automatic logic signed [NB_EXT_DEF-1:0] sxt(input logic [NB_DATA_DEF-1:0] v);
    return {{NB_GUARD{v[NB_DATA_DEF-1]}}, v};
  endfunction

endpackage

// File: rtl/fir_delay_line.sv
// Enable-gated tapped shift register. Tap 0 (lowest bits of o_taps) is the most
// recently shifted-in sample, tap DEPTH-1 the oldest. Reset and flush both clear it.
module fir_delay_line
  import fir_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int DEPTH   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_flush,
  input  logic                     i_en,
  input  logic [NB_DATA-1:0]       i_data,
  output logic [DEPTH*NB_DATA-1:0] o_taps
);

  // Shift a new sample in only when enabled, so idle gaps leave history untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      o_taps <= '0;
    end else if (i_en) begin
      o_taps <= {o_taps[(DEPTH-1)*NB_DATA-1:0], i_data};
    end
  end

endmodule

// File: rtl/fir_inv.sv
// Inverse of the forward shaping filter: recovers x[n] from y[n] by evaluating
//   x0 = y0 - (y1>>>1) - (y2>>>2) + x1 - x2 - x3
// in extended precision, wrapping the result back to NB_DATA bits. The wrapped value
// is fed back into the x history, which keeps the inversion exact even when the
// forward filter itself wrapped. Output is registered with one cycle of latency.
module fir_inv
  import fir_pkg::*;
#(
  parameter int NB_DATA = NB_DATA_DEF,
  parameter int NB_CNT  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_flush,
  input  logic               i_valid,
  input  logic [NB_DATA-1:0] i_data,
  output logic               o_valid,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_wrap,
  output logic               o_settled,
  output logic [NB_CNT-1:0]  o_count
);

  localparam int NB_EXT = NB_DATA + NB_GUARD;

  logic                      accept;
  logic [2*NB_DATA-1:0]      y_taps;
  logic [3*NB_DATA-1:0]      x_taps;
  logic [NB_DATA-1:0]        y1;
  logic [NB_DATA-1:0]        y2;
  logic [NB_DATA-1:0]        x1;
  logic [NB_DATA-1:0]        x2;
  logic [NB_DATA-1:0]        x3;
  logic signed [NB_EXT-1:0]  in_e;
  logic signed [NB_EXT-1:0]  y1_e;
  logic signed [NB_EXT-1:0]  y2_e;
  logic signed [NB_EXT-1:0]  x1_e;
  logic signed [NB_EXT-1:0]  x2_e;
  logic signed [NB_EXT-1:0]  x3_e;
  logic signed [NB_EXT-1:0]  x0_full;
  logic [NB_DATA-1:0]        x0;
  logic                      wrap_now;
  logic [NB_GUARD:0]         top_bits;
  state_t                    state;
  state_t                    state_next;
  logic [1:0]                fill_cnt;

  // A flush drops the sample offered in the same cycle.
  assign accept = i_valid && !i_flush;

  // Two past inputs y[n-1], y[n-2].
  fir_delay_line #(
    .NB_DATA (NB_DATA),
    .DEPTH   (2)
  ) u_y_hist (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_en    (accept),
    .i_data  (i_data),
    .o_taps  (y_taps)
  );

  // Three past wrapped reconstructions x[n-1], x[n-2], x[n-3].
  fir_delay_line #(
    .NB_DATA (NB_DATA),
    .DEPTH   (3)
  ) u_x_hist (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (i_flush),
    .i_en    (accept),
    .i_data  (x0),
    .o_taps  (x_taps)
  );

  assign y1 = y_taps[0*NB_DATA +: NB_DATA];
  assign y2 = y_taps[1*NB_DATA +: NB_DATA];
  assign x1 = x_taps[0*NB_DATA +: NB_DATA];
  assign x2 = x_taps[1*NB_DATA +: NB_DATA];
  assign x3 = x_taps[2*NB_DATA +: NB_DATA];

  // Sign-extend every operand so the six-term sum cannot overflow before wrapping.
  always_comb begin
    in_e = {{NB_GUARD{i_data[NB_DATA-1]}}, i_data};
    y1_e = {{NB_GUARD{y1[NB_DATA-1]}}, y1};
    y2_e = {{NB_GUARD{y2[NB_DATA-1]}}, y2};
    x1_e = {{NB_GUARD{x1[NB_DATA-1]}}, x1};
    x2_e = {{NB_GUARD{x2[NB_DATA-1]}}, x2};
    x3_e = {{NB_GUARD{x3[NB_DATA-1]}}, x3};
  end

  // Full-precision reconstruction, its modular wrap, and out-of-range detection.
  always_comb begin
    x0_full  = in_e - (y1_e >>> 1) - (y2_e >>> 2) + x1_e - x2_e - x3_e;
    x0       = x0_full[NB_DATA-1:0];
    top_bits = x0_full[NB_EXT-1:NB_DATA-1];
    wrap_now = !((&top_bits) || !(|top_bits));
  end

  // Registered output: valid pulse, data and wrap flag one cycle after acceptance.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_data  <= '0;
      o_wrap  <= 1'b0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
    end else begin
      o_valid <= i_valid;
      o_wrap  <= i_valid && wrap_now;
      if (i_valid) begin
        o_data <= x0;
      end
    end
  end

  // Saturating count of accepted samples since the last reset or flush.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      o_count <= '0;
    end else if (accept && (o_count != {NB_CNT{1'b1}})) begin
      o_count <= o_count + NB_CNT'(1);
    end
  end

  // Samples accepted while priming, used to decide when history is fully populated.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      fill_cnt <= '0;
    end else if ((state == FILL) && accept) begin
      fill_cnt <= fill_cnt + 2'd1;
    end
  end

  // Settle state register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // Move to RUN on the last priming sample; only a flush returns to FILL.
  always_comb begin
    state_next = state;
    o_settled  = 1'b0;
    case (state)
      FILL: begin
        if (accept && (fill_cnt == 2'(FILL_LEN - 1))) begin
          state_next = RUN;
        end
      end
      RUN: begin
        o_settled = 1'b1;
      end
      default: begin
        state_next = FILL;
      end
    endcase
    if (i_flush) begin
      state_next = FILL;
    end
  end

endmodule

// File: tb/tb_fir_inv.sv
// Self-checking bench for fir_inv: a directed vector table, hand-written gap/reset
// sequences, a randomized end-to-end run through a forward filter model, and a
// counter saturation check on a narrow-counter instance.
module tb_fir_inv;
  import fir_pkg::*;

  typedef struct {
    logic        valid;
    logic        flush;
    logic [7:0]  data;
    logic        exp_valid;
    logic [7:0]  exp_data;
    logic        exp_wrap;
    logic        exp_settled;
    logic [15:0] exp_count;
  } vec_t;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        valid;
  logic [7:0]  data;
  logic        ov;
  logic [7:0]  od;
  logic        ow;
  logic        os;
  logic [15:0] oc;
  logic        s_ov;
  logic [7:0]  s_od;
  logic        s_ow;
  logic        s_os;
  logic [3:0]  s_oc;

  int tests;
  int fails;

  logic [7:0] fx1, fx2, fx3, fy1, fy2;

  vec_t vecs[18];

  fir_inv #(.NB_DATA(8), .NB_CNT(16)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_flush   (flush),
    .i_valid   (valid),
    .i_data    (data),
    .o_valid   (ov),
    .o_data    (od),
    .o_wrap    (ow),
    .o_settled (os),
    .o_count   (oc)
  );

  fir_inv #(.NB_DATA(8), .NB_CNT(4)) dut_s (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_flush   (flush),
    .i_valid   (valid),
    .i_data    (data),
    .o_valid   (s_ov),
    .o_data    (s_od),
    .o_wrap    (s_ow),
    .o_settled (s_os),
    .o_count   (s_oc)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input logic v, input logic f, input logic [7:0] d,
                              input logic ev, input logic [7:0] ed, input logic ew,
                              input logic es, input logic [15:0] ec);
    vec_t r;
    r.valid = v; r.flush = f; r.data = d;
    r.exp_valid = ev; r.exp_data = ed; r.exp_wrap = ew;
    r.exp_settled = es; r.exp_count = ec;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic f, input logic [7:0] d);
    valid = v;
    flush = f;
    data  = d;
    @(posedge clk);
    #1;
  endtask

  task automatic modelReset();
    fx1 = '0; fx2 = '0; fx3 = '0; fy1 = '0; fy2 = '0;
  endtask

  task automatic doReset();
    rst = 1'b1; valid = 1'b0; flush = 1'b0; data = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
  endtask

  task automatic fwdStep(input logic [7:0] x, output logic [7:0] y);
    logic signed [NB_EXT_DEF-1:0] acc;
    acc = sxt(x) - sxt(fx1) + sxt(fx2) + sxt(fx3) + (sxt(fy1) >>> 1) + (sxt(fy2) >>> 2);
    y   = acc[7:0];
    fy2 = fy1; fy1 = y;
    fx3 = fx2; fx2 = fx1; fx1 = x;
  endtask

  initial begin
    logic [7:0] imp_in[4];
    logic [7:0] imp_out[4];
    logic [7:0] x;
    logic [7:0] y;
    logic       v;
    logic       f;
    int         accepted;

    tests = 0;
    fails = 0;
    rst = 1'b1; flush = 1'b0; valid = 1'b0; data = '0;
    modelReset();

    imp_in[0] = 8'h01; imp_in[1] = 8'hFF; imp_in[2] = 8'h00; imp_in[3] = 8'h00;
    imp_out[0] = 8'h01; imp_out[1] = 8'h00; imp_out[2] = 8'h00; imp_out[3] = 8'h00;

    // impulse, idle, flush
    vecs[0]  = mk(1, 0, 8'h01, 1, 8'h01, 0, 0, 16'd1);
    vecs[1]  = mk(1, 0, 8'hFF, 1, 8'h00, 0, 0, 16'd2);
    vecs[2]  = mk(1, 0, 8'h00, 1, 8'h00, 0, 1, 16'd3);
    vecs[3]  = mk(1, 0, 8'h00, 1, 8'h00, 0, 1, 16'd4);
    vecs[4]  = mk(0, 0, 8'h33, 0, 8'h00, 0, 1, 16'd4);
    vecs[5]  = mk(0, 1, 8'h00, 0, 8'h00, 0, 0, 16'd0);
    // wrap
    vecs[6]  = mk(1, 0, 8'h7F, 1, 8'h7F, 0, 0, 16'd1);
    vecs[7]  = mk(1, 0, 8'h7F, 1, 8'hBF, 1, 0, 16'd2);
    vecs[8]  = mk(0, 0, 8'h00, 0, 8'hBF, 0, 0, 16'd2);
    vecs[9]  = mk(0, 1, 8'h00, 0, 8'hBF, 0, 0, 16'd0);
    // flush mid-stream, then impulse recovery
    vecs[10] = mk(1, 0, 8'h7F, 1, 8'h7F, 0, 0, 16'd1);
    vecs[11] = mk(1, 0, 8'h7F, 1, 8'hBF, 1, 0, 16'd2);
    vecs[12] = mk(1, 0, 8'h7F, 1, 8'h61, 1, 1, 16'd3);
    vecs[13] = mk(1, 1, 8'h7F, 0, 8'h61, 0, 0, 16'd0);
    vecs[14] = mk(1, 0, 8'h01, 1, 8'h01, 0, 0, 16'd1);
    vecs[15] = mk(1, 0, 8'hFF, 1, 8'h00, 0, 0, 16'd2);
    vecs[16] = mk(1, 0, 8'h00, 1, 8'h00, 0, 1, 16'd3);
    vecs[17] = mk(1, 0, 8'h00, 1, 8'h00, 0, 1, 16'd4);

    @(posedge clk);
    #1;
    checkOutput("reset o_valid", 32'(ov), 32'd0);
    checkOutput("reset o_data", 32'(od), 32'd0);
    checkOutput("reset o_wrap", 32'(ow), 32'd0);
    checkOutput("reset o_settled", 32'(os), 32'd0);
    checkOutput("reset o_count", 32'(oc), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      applyStimulus(vecs[i].valid, vecs[i].flush, vecs[i].data);
      checkOutput($sformatf("vec%0d o_valid", i), 32'(ov), 32'(vecs[i].exp_valid));
      checkOutput($sformatf("vec%0d o_data", i), 32'(od), 32'(vecs[i].exp_data));
      checkOutput($sformatf("vec%0d o_wrap", i), 32'(ow), 32'(vecs[i].exp_wrap));
      checkOutput($sformatf("vec%0d o_settled", i), 32'(os), 32'(vecs[i].exp_settled));
      checkOutput($sformatf("vec%0d o_count", i), 32'(oc), 32'(vecs[i].exp_count));
    end

    // impulse with 5 idle cycles after every sample
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, imp_in[i]);
      checkOutput($sformatf("gap%0d o_valid", i), 32'(ov), 32'd1);
      checkOutput($sformatf("gap%0d o_data", i), 32'(od), 32'(imp_out[i]));
      for (int k = 0; k < 5; k++) begin
        applyStimulus(1'b0, 1'b0, 8'hA5);
        checkOutput($sformatf("gap%0d idle%0d o_valid", i, k), 32'(ov), 32'd0);
        checkOutput($sformatf("gap%0d idle%0d o_data", i, k), 32'(od), 32'(imp_out[i]));
      end
    end
    checkOutput("gap o_count", 32'(oc), 32'd4);
    checkOutput("gap o_settled", 32'(os), 32'd1);

    // reset mid-stream clears o_data as well
    applyStimulus(1'b1, 1'b0, 8'h55);
    checkOutput("pre-reset o_data", 32'(od), 32'h55);
    rst = 1'b1;
    applyStimulus(1'b1, 1'b0, 8'h22);
    rst = 1'b0;
    checkOutput("midreset o_data", 32'(od), 32'd0);
    checkOutput("midreset o_valid", 32'(ov), 32'd0);
    checkOutput("midreset o_count", 32'(oc), 32'd0);
    checkOutput("midreset o_settled", 32'(os), 32'd0);

    // end-to-end random through the forward model
    doReset();
    accepted = 0;
    while (accepted < 10000) begin
      v = ($urandom_range(99, 0) < 60);
      f = ($urandom_range(199, 0) == 0);
      x = 8'($urandom);
      y = 8'($urandom);
      if (f) begin
        modelReset();
      end else if (v) begin
        fwdStep(x, y);
      end
      applyStimulus(v, f, y);
      checkOutput("rand o_valid", 32'(ov), 32'(v && !f));
      if (v && !f) begin
        checkOutput("rand o_data", 32'(od), 32'(x));
        accepted++;
      end
    end

    // narrow counter saturates while filtering continues
    doReset();
    for (int i = 1; i <= 20; i++) begin
      x = 8'($urandom);
      fwdStep(x, y);
      applyStimulus(1'b1, 1'b0, y);
      checkOutput($sformatf("sat%0d o_data", i), 32'(s_od), 32'(x));
      checkOutput($sformatf("sat%0d o_valid", i), 32'(s_ov), 32'd1);
      checkOutput($sformatf("sat%0d o_count", i), 32'(s_oc), 32'((i > 15) ? 15 : i));
    end
    checkOutput("sat o_settled", 32'(s_os), 32'd1);
    checkOutput("wide o_count", 32'(oc), 32'd20);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
